// File: rtl/unidade_controle_pkg.sv
// Shared constants for the multicycle processor: opcodes, control-step encoding and
// instruction-word field positions. The ULA decodes the same opcode constants.
package unidade_controle_pkg;

    localparam int unsigned DataW = 16;
    localparam int unsigned NReg  = 8;
    localparam int unsigned RegW  = 3;

    localparam int unsigned OpMsb = 15;
    localparam int unsigned OpLsb = 12;
    localparam int unsigned RxMsb = 11;
    localparam int unsigned RxLsb = 9;
    localparam int unsigned RyMsb = 8;
    localparam int unsigned RyLsb = 6;

    localparam logic [3:0] OpLd   = 4'b0000;
    localparam logic [3:0] OpSt   = 4'b0001;
    localparam logic [3:0] OpMvnz = 4'b0010;
    localparam logic [3:0] OpMv   = 4'b0011;
    localparam logic [3:0] OpMvi  = 4'b0100;
    localparam logic [3:0] OpAdd  = 4'b0101;
    localparam logic [3:0] OpSub  = 4'b0110;
    localparam logic [3:0] OpOr   = 4'b0111;
    localparam logic [3:0] OpSlt  = 4'b1000;
    localparam logic [3:0] OpSll  = 4'b1001;
    localparam logic [3:0] OpSrl  = 4'b1010;

    typedef enum logic [1:0] {StT0, StT1, StT2, StT3} state_e;

    // ULA operations form one contiguous opcode range.
    function automatic logic is_alu(input logic [3:0] op);
        return (op >= OpAdd) && (op <= OpSrl);
    endfunction

endpackage

// File: rtl/unidade_controle_dec3to8.sv
// 3-bit register index to 8-bit one-hot select, forced to zero when disabled.
module dec3to8 (
    input  logic [2:0] idx_i,
    input  logic       en_i,
    output logic [7:0] onehot_o
);

    always_comb begin
        onehot_o = '0;
        if (en_i) begin
            onehot_o[idx_i] = 1'b1;
        end
    end

endmodule

// File: rtl/unidade_controle.sv
// Multicycle control FSM: fetches an instruction on Run and sequences bus selects, register
// enables, ULA opcode and memory strobes over T1..T3, pulsing Done on the last step.
module unidade_controle
    import unidade_controle_pkg::*;
(
    input  logic             Clock,
    input  logic             Reset,
    input  logic             Run,
    input  logic [DataW-1:0] DIN,
    input  logic             G_nz,
    output logic [NReg-1:0]  Rin,
    output logic [NReg-1:0]  Rout,
    output logic             Ain,
    output logic             Gin,
    output logic             Gout,
    output logic             DINout,
    output logic             ADDRin,
    output logic             DOUTin,
    output logic             W_D,
    output logic [3:0]       sinal,
    output logic             Done
);

    state_e           state_q, state_d;
    logic [DataW-1:0] ir_q, ir_d;

    logic [3:0]      op;
    logic [RegW-1:0] rx, ry;
    logic [NReg-1:0] rx_oh, ry_oh;
    logic            dec_en;
    logic            rin_rx, rout_rx, rout_ry;

    assign op = ir_q[OpMsb:OpLsb];
    assign rx = ir_q[RxMsb:RxLsb];
    assign ry = ir_q[RyMsb:RyLsb];

    logic unused_ir;
    assign unused_ir = ^ir_q[RyLsb-1:0];

    assign dec_en = (state_q != StT0);

    dec3to8 u_dec_rx (
        .idx_i    (rx),
        .en_i     (dec_en),
        .onehot_o (rx_oh)
    );

    dec3to8 u_dec_ry (
        .idx_i    (ry),
        .en_i     (dec_en),
        .onehot_o (ry_oh)
    );

    always_ff @(posedge Clock) begin
        if (Reset) begin
            state_q <= StT0;
            ir_q    <= '0;
        end else begin
            state_q <= state_d;
            ir_q    <= ir_d;
        end
    end

    always_comb begin
        state_d = state_q;
        ir_d    = ir_q;
        unique case (state_q)
            StT0: begin
                if (Run) begin
                    ir_d    = DIN;
                    state_d = StT1;
                end
            end
            StT1: state_d = (is_alu(op) || op == OpLd || op == OpSt) ? StT2 : StT0;
            StT2: state_d = (is_alu(op) || op == OpLd) ? StT3 : StT0;
            StT3: state_d = StT0;
            default: state_d = StT0;
        endcase
    end

    always_comb begin
        rin_rx  = 1'b0;
        rout_rx = 1'b0;
        rout_ry = 1'b0;
        Ain     = 1'b0;
        Gin     = 1'b0;
        Gout    = 1'b0;
        DINout  = 1'b0;
        ADDRin  = 1'b0;
        DOUTin  = 1'b0;
        W_D     = 1'b0;
        sinal   = 4'b0000;
        Done    = 1'b0;
        // Reset cycle suppresses every strobe so an aborted instruction leaves no trace.
        if (!Reset) begin
            unique case (state_q)
                StT1: begin
                    if (is_alu(op)) begin
                        rout_rx = 1'b1;
                        Ain     = 1'b1;
                    end else begin
                        case (op)
                            OpMv: begin
                                rout_ry = 1'b1;
                                rin_rx  = 1'b1;
                                Done    = 1'b1;
                            end
                            OpMvi: begin
                                DINout = 1'b1;
                                rin_rx = 1'b1;
                                Done   = 1'b1;
                            end
                            OpMvnz: begin
                                rout_ry = 1'b1;
                                rin_rx  = G_nz;
                                Done    = 1'b1;
                            end
                            OpLd, OpSt: begin
                                rout_ry = 1'b1;
                                ADDRin  = 1'b1;
                            end
                            default: Done = 1'b1;
                        endcase
                    end
                end
                StT2: begin
                    if (is_alu(op)) begin
                        rout_ry = 1'b1;
                        sinal   = op;
                        Gin     = 1'b1;
                    end else if (op == OpSt) begin
                        rout_rx = 1'b1;
                        DOUTin  = 1'b1;
                        W_D     = 1'b1;
                        Done    = 1'b1;
                    end
                end
                StT3: begin
                    if (is_alu(op)) begin
                        Gout   = 1'b1;
                        rin_rx = 1'b1;
                        Done   = 1'b1;
                    end else if (op == OpLd) begin
                        DINout = 1'b1;
                        rin_rx = 1'b1;
                        Done   = 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign Rin  = rin_rx ? rx_oh : '0;
    assign Rout = rout_rx ? rx_oh : (rout_ry ? ry_oh : '0);

endmodule

// File: tb/tb_unidade_controle.sv
// Directed, table-driven bench for the control FSM; each row is one clock cycle of
// inputs with the outputs expected during that cycle.
module tb_unidade_controle;

    typedef struct packed {
        logic        rst;
        logic        run;
        logic [15:0] din;
        logic        gnz;
        logic [7:0]  rin;
        logic [7:0]  rout;
        logic [7:0]  flags;
        logic [3:0]  sinal;
    } vec_t;

    localparam logic [7:0] FAin    = 8'h80;
    localparam logic [7:0] FGin    = 8'h40;
    localparam logic [7:0] FGout   = 8'h20;
    localparam logic [7:0] FDinout = 8'h10;
    localparam logic [7:0] FAddrin = 8'h08;
    localparam logic [7:0] FDoutin = 8'h04;
    localparam logic [7:0] FWd     = 8'h02;
    localparam logic [7:0] FDone   = 8'h01;

    logic        Clock = 1'b0;
    logic        Reset = 1'b1;
    logic        Run = 1'b0;
    logic [15:0] DIN = '0;
    logic        G_nz = 1'b0;
    logic [7:0]  Rin, Rout;
    logic        Ain, Gin, Gout, DINout, ADDRin, DOUTin, W_D, Done;
    logic [3:0]  sinal;

    int checks = 0;
    int failures = 0;
    int row_id = 0;
    vec_t rows[$];

    unidade_controle dut (
        .Clock  (Clock),
        .Reset  (Reset),
        .Run    (Run),
        .DIN    (DIN),
        .G_nz   (G_nz),
        .Rin    (Rin),
        .Rout   (Rout),
        .Ain    (Ain),
        .Gin    (Gin),
        .Gout   (Gout),
        .DINout (DINout),
        .ADDRin (ADDRin),
        .DOUTin (DOUTin),
        .W_D    (W_D),
        .sinal  (sinal),
        .Done   (Done)
    );

    always #5 Clock = ~Clock;

    function automatic vec_t mk(input logic rst, input logic run, input logic [15:0] din,
                                input logic gnz, input logic [7:0] rin, input logic [7:0] rout,
                                input logic [7:0] flags, input logic [3:0] sg);
        vec_t v;
        v.rst = rst; v.run = run; v.din = din; v.gnz = gnz;
        v.rin = rin; v.rout = rout; v.flags = flags; v.sinal = sg;
        return v;
    endfunction

    // Drive one cycle of inputs, check outputs mid-cycle, then advance past the edge.
    task automatic step(input vec_t r);
        logic [7:0] got_flags;
        int nbus;
        Reset = r.rst;
        Run   = r.run;
        DIN   = r.din;
        G_nz  = r.gnz;
        @(negedge Clock);
        got_flags = {Ain, Gin, Gout, DINout, ADDRin, DOUTin, W_D, Done};
        checks++;
        if ({Rin, Rout, got_flags, sinal} !== {r.rin, r.rout, r.flags, r.sinal}) begin
            failures++;
            $display("FAIL row%0d outputs: got Rin=%h Rout=%h flags=%b sinal=%h, want Rin=%h Rout=%h flags=%b sinal=%h",
                     row_id, Rin, Rout, got_flags, sinal, r.rin, r.rout, r.flags, r.sinal);
        end
        nbus = $countones(Rout) + int'(Gout) + int'(DINout);
        checks++;
        if (nbus > 1) begin
            failures++;
            $display("FAIL row%0d bus_onehot: got %0d drivers, want at most 1", row_id, nbus);
        end
        row_id++;
        @(posedge Clock);
        #1;
    endtask

    initial begin
        logic [3:0] o;

        repeat (3) rows.push_back(mk(1, 0, 16'h0000, 0, 8'h00, 8'h00, 8'h00, 4'h0));
        repeat (5) rows.push_back(mk(0, 0, 16'h0000, 0, 8'h00, 8'h00, 8'h00, 4'h0));

        // mvi R2, #0x00AB
        rows.push_back(mk(0, 1, 16'h4400, 0, 8'h00, 8'h00, 8'h00, 4'h0));
        rows.push_back(mk(0, 0, 16'h00AB, 0, 8'h04, 8'h00, FDinout | FDone, 4'h0));

        // ULA ops R1,R2 for add..srl
        for (int op = 5; op <= 10; op++) begin
            o = 4'(op);
            rows.push_back(mk(0, 1, {o, 12'h280}, 0, 8'h00, 8'h00, 8'h00, 4'h0));
            rows.push_back(mk(0, 0, 16'h0000, 0, 8'h00, 8'h02, FAin, 4'h0));
            rows.push_back(mk(0, 0, 16'h0000, 0, 8'h00, 8'h04, FGin, o));
            rows.push_back(mk(0, 0, 16'h0000, 0, 8'h02, 8'h00, FGout | FDone, 4'h0));
        end

        // add R3,R3
        rows.push_back(mk(0, 1, 16'h56C0, 0, 8'h00, 8'h00, 8'h00, 4'h0));
        rows.push_back(mk(0, 0, 16'h0000, 0, 8'h00, 8'h08, FAin, 4'h0));
        rows.push_back(mk(0, 0, 16'h0000, 0, 8'h00, 8'h08, FGin, 4'h5));
        rows.push_back(mk(0, 0, 16'h0000, 0, 8'h08, 8'h00, FGout | FDone, 4'h0));

        // mv R7,R0
        rows.push_back(mk(0, 1, 16'h3E00, 0, 8'h00, 8'h00, 8'h00, 4'h0));
        rows.push_back(mk(0, 0, 16'h0000, 0, 8'h80, 8'h01, FDone, 4'h0));

        // mvnz R0,R5 with G_nz = 0, then G_nz = 1
        rows.push_back(mk(0, 1, 16'h2140, 0, 8'h00, 8'h00, 8'h00, 4'h0));
        rows.push_back(mk(0, 0, 16'h0000, 0, 8'h00, 8'h20, FDone, 4'h0));
        rows.push_back(mk(0, 1, 16'h2140, 1, 8'h00, 8'h00, 8'h00, 4'h0));
        rows.push_back(mk(0, 0, 16'h0000, 1, 8'h01, 8'h20, FDone, 4'h0));

        // st R3,R4
        rows.push_back(mk(0, 1, 16'h1700, 0, 8'h00, 8'h00, 8'h00, 4'h0));
        rows.push_back(mk(0, 0, 16'h0000, 0, 8'h00, 8'h10, FAddrin, 4'h0));
        rows.push_back(mk(0, 0, 16'h0000, 0, 8'h00, 8'h08, FDoutin | FWd | FDone, 4'h0));

        // ld R6,R1
        rows.push_back(mk(0, 1, 16'h0C40, 0, 8'h00, 8'h00, 8'h00, 4'h0));
        rows.push_back(mk(0, 0, 16'h0000, 0, 8'h00, 8'h02, FAddrin, 4'h0));
        rows.push_back(mk(0, 0, 16'h0000, 0, 8'h00, 8'h00, 8'h00, 4'h0));
        rows.push_back(mk(0, 0, 16'h0000, 0, 8'h40, 8'h00, FDinout | FDone, 4'h0));

        // illegal opcode: Done only, then back in T0
        rows.push_back(mk(0, 1, 16'hF000, 0, 8'h00, 8'h00, 8'h00, 4'h0));
        rows.push_back(mk(0, 0, 16'h0000, 0, 8'h00, 8'h00, FDone, 4'h0));
        rows.push_back(mk(0, 0, 16'h0000, 0, 8'h00, 8'h00, 8'h00, 4'h0));

        #1;
        foreach (rows[i]) step(rows[i]);

        // Reset during T2 of add: no Gin/Rin/Done, then a clean T0 and a fresh fetch
        step(mk(0, 1, 16'h5280, 0, 8'h00, 8'h00, 8'h00, 4'h0));
        step(mk(0, 0, 16'h0000, 0, 8'h00, 8'h02, FAin, 4'h0));
        step(mk(1, 0, 16'h0000, 0, 8'h00, 8'h00, 8'h00, 4'h0));
        step(mk(0, 0, 16'h0000, 0, 8'h00, 8'h00, 8'h00, 4'h0));
        step(mk(0, 0, 16'h0000, 0, 8'h00, 8'h00, 8'h00, 4'h0));
        step(mk(0, 1, 16'h4400, 0, 8'h00, 8'h00, 8'h00, 4'h0));
        step(mk(0, 0, 16'h0000, 0, 8'h04, 8'h00, FDinout | FDone, 4'h0));

        // Run held high: ignored mid-instruction, re-fetches on every T0
        step(mk(0, 1, 16'h5280, 0, 8'h00, 8'h00, 8'h00, 4'h0));
        step(mk(0, 1, 16'h4400, 0, 8'h00, 8'h02, FAin, 4'h0));
        step(mk(0, 1, 16'h4400, 0, 8'h00, 8'h04, FGin, 4'h5));
        step(mk(0, 1, 16'h4400, 0, 8'h02, 8'h00, FGout | FDone, 4'h0));
        step(mk(0, 1, 16'h3E00, 0, 8'h00, 8'h00, 8'h00, 4'h0));
        step(mk(0, 1, 16'h4400, 0, 8'h80, 8'h01, FDone, 4'h0));
        step(mk(0, 1, 16'h4400, 0, 8'h00, 8'h00, 8'h00, 4'h0));
        step(mk(0, 0, 16'h0000, 0, 8'h04, 8'h00, FDinout | FDone, 4'h0));
        step(mk(0, 0, 16'h0000, 0, 8'h00, 8'h00, 8'h00, 4'h0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
